imm_ext_arbiter: RTL and testbench
==================================

Name: imm_ext_arbiter

Overview:
- Shares one 16-to-32-bit immediate-extension datapath between two requesters: requester 0 is decode-stage immediate extension, requester 1 is memory-stage halfword/byte load extension.
- Arbitrates round-robin, performs the extension selected by a per-request mode, and holds the result in a single-entry output register with valid/ready backpressure.
- Keeps per-requester saturating grant counters for performance debug.
- Sits between the ID/MEM stage logic and the shared extender path.

Parameters:
- IN_W, 16, input immediate/load data width.
- OUT_W, 32, extended result width.
- CNT_W, 8, width of each saturating grant counter.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_data  input  IN_W  requester 0 operand.
- req0_mode  input  2  requester 0 extension mode.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid  input  1  requester 1 has a request.
- req1_data  input  IN_W  requester 1 operand.
- req1_mode  input  2  requester 1 extension mode.
- req1_ready  output  1  requester 1 request accepted this cycle.
- out_valid  output  1  result register holds a valid result.
- out_data  output  OUT_W  extended result.
- out_id  output  1  requester that produced out_data.
- out_ready  input  1  consumer accepts the result this cycle.
- grant_cnt0  output  CNT_W  saturating count of grants to requester 0.
- grant_cnt1  output  CNT_W  saturating count of grants to requester 1.

Behaviour:
- Reset (synchronous, Reset=1 at the edge):
  - out_valid=0, out_data=0, out_id=0, grant_cnt0=grant_cnt1=0.
  - Round-robin pointer last_grant=1, so requester 0 has priority first.
  - An in-flight result is discarded. Reset overrides every other event in the same cycle.
- Extension modes (combinational on the granted operand):
  - 00: sign-extend in[15:0]; bits 31:16 = in[15].
  - 01: zero-extend in[15:0].
  - 10: upper-immediate: {in[15:0], 16'h0000}.
  - 11: sign-extend byte: bits 31:8 = in[7], bits 7:0 = in[7:0]; in[15:8] is ignored.
- Acceptance:
  - can_accept = !out_valid | out_ready.
  - The arbiter grants only when can_accept=1 and at least one reqN_valid=1.
  - reqN_ready is combinational: 1 only for the granted requester in that cycle. At most one ready is high per cycle.
  - reqN_ready never depends on reqN_valid of the same requester beyond the grant decision (no combinational loop through the requester).
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins; last_grant updates to the winner on every grant.
  - No grant: last_grant holds.
- Output register, updated on a grant edge:
  - out_data = extension result, out_id = winner, out_valid = 1.
  - Latency: request accepted at edge N gives a result visible after edge N, i.e. one cycle.
- Output hold and throughput:
  - No grant and out_ready=1: out_valid clears at the edge.
  - out_valid=1 and out_ready=0: out_data and out_id hold stable, and no grant is issued (both readies 0).
  - Simultaneous consume and grant in the same cycle is allowed, giving full throughput of one result per cycle.
- Grant counters:
  - grant_cntN increments on each grant to N.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Requests are not queued. A requester must hold valid and its data/mode stable until it sees ready.

Test Plan:
- Reset, then req0 valid, data=16'h8001, mode=00, out_ready=1 → req0_ready=1 in that cycle; next cycle out_valid=1, out_data=32'hFFFF8001, out_id=0.
- Mode sweep on data=16'h80F0: mode 01 → 32'h000080F0; mode 10 → 32'h80F00000; mode 11 → 32'hFFFFFFF0; data=16'h7F7F mode 00 → 32'h00007F7F.
- Both requesters valid continuously with out_ready=1 → grants alternate 0,1,0,1; out_id follows the same sequence with one result per cycle; grant_cnt0 and grant_cnt1 each read 2 after 4 cycles.
- Result pending with out_ready=0 for 3 cycles while both requesters are valid → both readies stay 0; out_data and out_id stay stable; raising out_ready consumes the result and grants the next request in the same cycle.
- Requester 0 alone for 300 grants with CNT_W=8 → grant_cnt0 = 255 (saturated); grant_cnt1 = 0.
- Assert Reset while out_valid=1 and both requesters are valid → next cycle out_valid=0, counters=0, no ready asserted; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
//
// Shares one 16-to-32-bit immediate-extension datapath between two requesters.
// Requester 0 is decode-stage immediate extension. Requester 1 is memory-stage
// halfword/byte load extension. Requests are arbitrated round-robin. The
// winner's operand is extended according to its mode. The result is held in a
// single-entry output register with valid/ready handshaking. Two saturating
// grant counters support performance debugging.
//
// Extension modes:
//   2'b00  sign-extend the full IN_W operand
//   2'b01  zero-extend the full IN_W operand
//   2'b10  upper immediate: operand placed in the top bits, zeros below
//   2'b11  sign-extend the low byte; the upper operand bits are ignored
//
// Ports:
//   Clk         system clock, all state changes on the rising edge
//   Reset       synchronous active-high reset
//   req0_valid  requester 0 has a request
//   req0_data   requester 0 operand (IN_W)
//   req0_mode   requester 0 extension mode (2)
//   req0_ready  requester 0 accepted this cycle (combinational)
//   req1_valid  requester 1 has a request
//   req1_data   requester 1 operand (IN_W)
//   req1_mode   requester 1 extension mode (2)
//   req1_ready  requester 1 accepted this cycle (combinational)
//   out_valid   result register holds a valid result
//   out_data    extended result (OUT_W)
//   out_id      requester that produced out_data
//   out_ready   consumer accepts the result this cycle
//   grant_cnt0  saturating grant count for requester 0 (CNT_W)
//   grant_cnt1  saturating grant count for requester 1 (CNT_W)

module imm_ext_arbiter #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,

    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_data,
    input  logic [1:0]       req0_mode,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_data,
    input  logic [1:0]       req1_mode,
    output logic             req1_ready,

    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    // Encodings of the extension mode field.
    typedef enum logic [1:0] {
        MODE_SEXT  = 2'b00,
        MODE_ZEXT  = 2'b01,
        MODE_UPPER = 2'b10,
        MODE_SBYTE = 2'b11
    } ext_mode_t;

    // Round-robin pointer: which requester received the most recent grant.
    logic             last_grant;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic             winner;
    logic [IN_W-1:0]  sel_data;
    ext_mode_t        sel_mode;
    logic [OUT_W-1:0] ext_result;

    // A new result can be accepted when the output register is empty, or
    // when the value it holds is consumed in this same cycle. The second case
    // allows one result per cycle.
    assign can_accept = !out_valid || out_ready;

    // Grant decision. When only one requester is valid, that requester wins.
    // When both are valid, the requester that did not win last time wins.
    // Reset suppresses every grant, so no ready is raised while the block
    // is being cleared.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Reset && can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant_any  = grant0 || grant1;
    assign winner     = grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Route the winning requester's operand and mode into the shared extender.
    always_comb begin
        sel_data = req0_data;
        sel_mode = ext_mode_t'(req0_mode);
        if (grant1) begin
            sel_data = req1_data;
            sel_mode = ext_mode_t'(req1_mode);
        end
    end

    // Shared extension datapath.
    always_comb begin
        ext_result = '0;
        case (sel_mode)
            MODE_SEXT:  ext_result = {{(OUT_W-IN_W){sel_data[IN_W-1]}}, sel_data};
            MODE_ZEXT:  ext_result = {{(OUT_W-IN_W){1'b0}}, sel_data};
            MODE_UPPER: ext_result = {sel_data, {(OUT_W-IN_W){1'b0}}};
            MODE_SBYTE: ext_result = {{(OUT_W-8){sel_data[7]}}, sel_data[7:0]};
            default:    ext_result = '0;
        endcase
    end

    // Output register and round-robin pointer.
    // A grant loads a fresh result, which may replace one consumed in the same
    // cycle. Without a grant, a consumed result simply empties the register.
    // While the register is full and not consumed, no grant occurs, so
    // out_data and out_id hold stable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (grant_any) begin
            out_valid  <= 1'b1;
            out_data   <= ext_result;
            out_id     <= winner;
            last_grant <= winner;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Saturating grant counters. Each counter stops at all-ones instead of
    // wrapping, so a long-running count never reads as a small value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (grant1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter
//
// Directed testbench for imm_ext_arbiter. The expected values are computed by
// hand from the extension rules and the round-robin order. Inputs change 1 ns
// after a rising edge. Combinational readies are sampled 1 ns after that.
// Registered outputs are sampled 1 ns after the following edge.

module tb_imm_ext_arbiter;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int CNT_W = 8;

    logic             Clk;
    logic             Reset;
    logic             req0_valid;
    logic [IN_W-1:0]  req0_data;
    logic [1:0]       req0_mode;
    logic             req0_ready;
    logic             req1_valid;
    logic [IN_W-1:0]  req1_data;
    logic [1:0]       req1_mode;
    logic             req1_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_id;
    logic             out_ready;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    int compared   = 0;
    int mismatched = 0;

    imm_ext_arbiter #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_mode (req0_mode),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_mode (req1_mode),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
    );

    // Free-running 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive every requester/consumer input, then let combinational logic settle.
    task automatic apply_stimulus(input logic v0, input logic [IN_W-1:0] d0, input logic [1:0] m0,
                                  input logic v1, input logic [IN_W-1:0] d1, input logic [1:0] m1,
                                  input logic ordy);
        req0_valid = v0;
        req0_data  = d0;
        req0_mode  = m0;
        req1_valid = v1;
        req1_data  = d1;
        req1_mode  = m1;
        out_ready  = ordy;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        Reset = 1'b1;
        apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        tick();

        // Reset state.
        check_output("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_output("rst_out_data", out_data, 32'h0);
        check_output("rst_out_id", {31'b0, out_id}, 32'h0);
        check_output("rst_cnt0", {24'b0, grant_cnt0}, 32'h0);
        check_output("rst_cnt1", {24'b0, grant_cnt1}, 32'h0);
        Reset = 1'b0;

        // The first request from requester 0 is accepted and then appears one cycle later.
        apply_stimulus(1'b1, 16'h8001, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        check_output("first_req0_ready", {31'b0, req0_ready}, 32'h1);
        check_output("first_req1_ready", {31'b0, req1_ready}, 32'h0);
        tick();
        check_output("first_out_valid", {31'b0, out_valid}, 32'h1);
        check_output("first_out_data", out_data, 32'hFFFF8001);
        check_output("first_out_id", {31'b0, out_id}, 32'h0);

        // Mode sweep. Requester 0 is the only valid requester and the output is consumed every cycle.
        apply_stimulus(1'b1, 16'h80F0, 2'b01, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("mode01", out_data, 32'h000080F0);
        apply_stimulus(1'b1, 16'h80F0, 2'b10, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("mode10", out_data, 32'h80F00000);
        apply_stimulus(1'b1, 16'h80F0, 2'b11, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("mode11", out_data, 32'hFFFFFFF0);
        apply_stimulus(1'b1, 16'h7F7F, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("mode00_pos", out_data, 32'h00007F7F);
        apply_stimulus(1'b1, 16'h1280, 2'b11, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("mode11_ignore_hi", out_data, 32'hFFFFFF80);
        check_output("sweep_cnt0", {24'b0, grant_cnt0}, 32'd6);

        // Reset again so that round-robin starts with requester 0 and the counters start from zero.
        Reset = 1'b1;
        apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        Reset = 1'b0;

        // Both requesters are continuously valid, so grants must alternate 0,1,0,1.
        // Requester 0 expects 0x00000001 (0x0001 zero-extended).
        // Requester 1 expects 0xFFFFFFFF (byte 0xFF sign-extended).
        apply_stimulus(1'b1, 16'h0001, 2'b01, 1'b1, 16'h00FF, 2'b11, 1'b1);
        check_output("rr0_req0_ready", {31'b0, req0_ready}, 32'h1);
        check_output("rr0_req1_ready", {31'b0, req1_ready}, 32'h0);
        tick();
        check_output("rr0_out_id", {31'b0, out_id}, 32'h0);
        check_output("rr0_out_data", out_data, 32'h00000001);
        check_output("rr1_req1_ready", {31'b0, req1_ready}, 32'h1);
        tick();
        check_output("rr1_out_id", {31'b0, out_id}, 32'h1);
        check_output("rr1_out_data", out_data, 32'hFFFFFFFF);
        check_output("rr2_req0_ready", {31'b0, req0_ready}, 32'h1);
        tick();
        check_output("rr2_out_id", {31'b0, out_id}, 32'h0);
        check_output("rr3_req1_ready", {31'b0, req1_ready}, 32'h1);
        tick();
        check_output("rr3_out_id", {31'b0, out_id}, 32'h1);
        check_output("rr3_out_valid", {31'b0, out_valid}, 32'h1);
        check_output("rr_cnt0", {24'b0, grant_cnt0}, 32'd2);
        check_output("rr_cnt1", {24'b0, grant_cnt1}, 32'd2);

        // Backpressure. The result from requester 1 must hold for 3 cycles and no grant may be issued.
        apply_stimulus(1'b1, 16'h0001, 2'b01, 1'b1, 16'h00FF, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_output("bp_req0_ready", {31'b0, req0_ready}, 32'h0);
            check_output("bp_req1_ready", {31'b0, req1_ready}, 32'h0);
            tick();
            check_output("bp_out_valid", {31'b0, out_valid}, 32'h1);
            check_output("bp_out_data", out_data, 32'hFFFFFFFF);
            check_output("bp_out_id", {31'b0, out_id}, 32'h1);
        end
        check_output("bp_cnt1_hold", {24'b0, grant_cnt1}, 32'd2);

        // Raising out_ready consumes the held result and grants requester 0 in the same cycle.
        out_ready = 1'b1;
        #1;
        check_output("bp_release_req0_ready", {31'b0, req0_ready}, 32'h1);
        check_output("bp_release_req1_ready", {31'b0, req1_ready}, 32'h0);
        tick();
        check_output("bp_release_out_id", {31'b0, out_id}, 32'h0);
        check_output("bp_release_out_data", out_data, 32'h00000001);
        check_output("bp_release_cnt0", {24'b0, grant_cnt0}, 32'd3);

        // Assert Reset while a result is valid and both requesters are valid.
        apply_stimulus(1'b1, 16'h0001, 2'b01, 1'b1, 16'h00FF, 2'b11, 1'b0);
        Reset = 1'b1;
        #1;
        check_output("rstmid_req0_ready", {31'b0, req0_ready}, 32'h0);
        check_output("rstmid_req1_ready", {31'b0, req1_ready}, 32'h0);
        tick();
        Reset = 1'b0;
        check_output("rstmid_out_valid", {31'b0, out_valid}, 32'h0);
        check_output("rstmid_cnt0", {24'b0, grant_cnt0}, 32'h0);
        check_output("rstmid_cnt1", {24'b0, grant_cnt1}, 32'h0);
        #1;
        check_output("rstmid_first_req0_ready", {31'b0, req0_ready}, 32'h1);
        check_output("rstmid_first_req1_ready", {31'b0, req1_ready}, 32'h0);
        tick();
        check_output("rstmid_first_out_id", {31'b0, out_id}, 32'h0);

        // Saturation. Requester 0 alone receives 300 grants, and its counter must stop at 255.
        Reset = 1'b1;
        apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        Reset = 1'b0;
        apply_stimulus(1'b1, 16'h0042, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 253) begin
                check_output("sat_cnt0_254", {24'b0, grant_cnt0}, 32'd254);
            end
            if (i == 254) begin
                check_output("sat_cnt0_255", {24'b0, grant_cnt0}, 32'd255);
            end
        end
        check_output("sat_cnt0_final", {24'b0, grant_cnt0}, 32'd255);
        check_output("sat_cnt1_final", {24'b0, grant_cnt1}, 32'd0);
        check_output("sat_out_data", out_data, 32'h00000042);

        // With no requesters and out_ready high, the register empties.
        apply_stimulus(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
        tick();
        check_output("drain_out_valid", {31'b0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
